// File: rtl/schedws.sv
// schedws: instruction-phase sequencer for the cpu3 datapath.
// Walks HALT -> F -> E -> M -> W with run/halt/single-step control and
// stretchable fetch and memory phases (minimum wait counts plus mem_rdy).
// Phase levels (ph_sel) steer the address mux; one-cycle completion strobes
// (phf/phe/phm/phw) fire the datapath register enables exactly once per phase.
//
// Handshake: mem_rdy is a completion qualifier, not a valid/ready pair. It is
// looked at only in F or M once the minimum-wait counter has reached zero; the
// phase completes in the first such cycle with mem_rdy=1. The memory sees that
// completion as the matching strobe (phf or phm) in the same cycle.
module schedws #(
    parameter int FETCH_WS  = 0,
    parameter int MEM_WS    = 0,
    parameter int WS_WIDTH  = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 step,
    input  logic                 mem_rdy,
    output logic [3:0]           ph_sel,
    output logic                 phf,
    output logic                 phe,
    output logic                 phm,
    output logic                 phw,
    output logic                 waiting,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] inst_cnt,
    output logic [2:0]           clk_stat
);

    // State codes double as the clk_stat debug encoding.
    localparam logic [2:0] ST_HALT = 3'd0;
    localparam logic [2:0] ST_F    = 3'd1;
    localparam logic [2:0] ST_E    = 3'd2;
    localparam logic [2:0] ST_M    = 3'd3;
    localparam logic [2:0] ST_W    = 3'd4;

    localparam logic [WS_WIDTH-1:0] FETCH_LOAD = WS_WIDTH'(FETCH_WS);
    localparam logic [WS_WIDTH-1:0] MEM_LOAD   = WS_WIDTH'(MEM_WS);

    logic [2:0]           r_state;
    logic [WS_WIDTH-1:0]  r_wait_cnt;
    logic [CNT_WIDTH-1:0] r_inst_cnt;

    logic [2:0]           w_next_state;
    logic                 w_in_f;
    logic                 w_in_e;
    logic                 w_in_m;
    logic                 w_in_w;
    logic                 w_cnt_zero;
    logic                 w_phf;
    logic                 w_phm;

    assign w_in_f     = (r_state == ST_F);
    assign w_in_e     = (r_state == ST_E);
    assign w_in_m     = (r_state == ST_M);
    assign w_in_w     = (r_state == ST_W);
    assign w_cnt_zero = (r_wait_cnt == '0);

    // mem_rdy only counts once the minimum wait has elapsed.
    assign w_phf = w_in_f & w_cnt_zero & mem_rdy;
    assign w_phm = w_in_m & w_cnt_zero & mem_rdy;

    // Next-state decode; run is only consulted in HALT and at the end of W.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_HALT: if (run || step) w_next_state = ST_F;
            ST_F:    if (w_phf) w_next_state = ST_E;
            ST_E:    w_next_state = ST_M;
            ST_M:    if (w_phm) w_next_state = ST_W;
            ST_W:    w_next_state = run ? ST_F : ST_HALT;
            default: w_next_state = ST_HALT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_HALT;
        else        r_state <= w_next_state;
    end

    // Wait counter: loads on phase entry, counts down while in F or M.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
        end else if (w_next_state == ST_F && !w_in_f) begin
            r_wait_cnt <= FETCH_LOAD;
        end else if (w_next_state == ST_M && !w_in_m) begin
            r_wait_cnt <= MEM_LOAD;
        end else if ((w_in_f || w_in_m) && !w_cnt_zero) begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
        end
    end

    // Retired-instruction counter, bumped in every W cycle, wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      r_inst_cnt <= '0;
        else if (w_in_w) r_inst_cnt <= r_inst_cnt + CNT_WIDTH'(1);
    end

    assign ph_sel   = {w_in_w, w_in_m, w_in_e, w_in_f};
    assign phf      = w_phf;
    assign phe      = w_in_e;
    assign phm      = w_phm;
    assign phw      = w_in_w;
    assign waiting  = (w_in_f & ~w_phf) | (w_in_m & ~w_phm);
    assign halted   = (r_state == ST_HALT);
    assign inst_cnt = r_inst_cnt;
    assign clk_stat = r_state;

endmodule

// File: tb/tb_schedws.sv
// Directed bench for schedws. Instance a: zero waits, 4-bit retire counter.
// Instance b: FETCH_WS=2, MEM_WS=1, default counter width. Both share inputs.
module tb_schedws;

    logic clk;
    logic reset;
    logic run;
    logic step;
    logic mem_rdy;

    logic [3:0]  a_ph_sel;
    logic        a_phf, a_phe, a_phm, a_phw, a_waiting, a_halted;
    logic [3:0]  a_inst_cnt;
    logic [2:0]  a_clk_stat;

    logic [3:0]  b_ph_sel;
    logic        b_phf, b_phe, b_phm, b_phw, b_waiting, b_halted;
    logic [31:0] b_inst_cnt;
    logic [2:0]  b_clk_stat;

    int checks;
    int errors;

    schedws #(.FETCH_WS(0), .MEM_WS(0), .WS_WIDTH(4), .CNT_WIDTH(4)) u_dut_a (
        .clk(clk), .reset(reset), .run(run), .step(step), .mem_rdy(mem_rdy),
        .ph_sel(a_ph_sel), .phf(a_phf), .phe(a_phe), .phm(a_phm), .phw(a_phw),
        .waiting(a_waiting), .halted(a_halted), .inst_cnt(a_inst_cnt),
        .clk_stat(a_clk_stat)
    );

    schedws #(.FETCH_WS(2), .MEM_WS(1), .WS_WIDTH(4), .CNT_WIDTH(32)) u_dut_b (
        .clk(clk), .reset(reset), .run(run), .step(step), .mem_rdy(mem_rdy),
        .ph_sel(b_ph_sel), .phf(b_phf), .phe(b_phe), .phm(b_phm), .phw(b_phw),
        .waiting(b_waiting), .halted(b_halted), .inst_cnt(b_inst_cnt),
        .clk_stat(b_clk_stat)
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle; return 1 unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset both instances, then release with the given run level.
    task automatic apply_reset(input logic run_v, input logic rdy_v);
        reset   = 1'b0;
        step    = 1'b0;
        run     = 1'b0;
        mem_rdy = 1'b1;
        tick();
        tick();
        reset   = 1'b1;
        run     = run_v;
        mem_rdy = rdy_v;
    endtask

    task automatic test_reset();
        logic [3:0] exp_sel;
        apply_reset(1'b1, 1'b1);
        #1;
        checks++;
        if (a_halted !== 1'b1 || a_clk_stat !== 3'd0) begin
            errors++;
            $display("FAIL reset_halt: halted=%b clk_stat=%0d, required 1/0", a_halted, a_clk_stat);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_sel = 4'b0001 << (i % 4);
            checks++;
            if ({a_phw, a_phm, a_phe, a_phf} !== exp_sel || a_ph_sel !== exp_sel ||
                a_waiting !== 1'b0 || a_clk_stat !== 3'(i % 4 + 1) || a_inst_cnt !== 4'(i / 4)) begin
                errors++;
                $display("FAIL free_run c%0d: sel=%b strb=%b wait=%b stat=%0d cnt=%0d, required sel=strb=%b wait=0 stat=%0d cnt=%0d",
                         i, a_ph_sel, {a_phw, a_phm, a_phe, a_phf}, a_waiting, a_clk_stat, a_inst_cnt,
                         exp_sel, i % 4 + 1, i / 4);
            end
        end
        tick();
        checks++;
        if (a_inst_cnt !== 4'd3 || a_clk_stat !== 3'd1) begin
            errors++;
            $display("FAIL free_run_count: cnt=%0d stat=%0d, required 3/1", a_inst_cnt, a_clk_stat);
        end
        tick();
        // Now in E; assert reset between edges and expect immediate effect.
        reset = 1'b0;
        #1;
        checks++;
        if (a_ph_sel !== 4'b0 || {a_phw, a_phm, a_phe, a_phf} !== 4'b0 || a_waiting !== 1'b0 ||
            a_halted !== 1'b1 || a_clk_stat !== 3'd0 || a_inst_cnt !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: sel=%b strb=%b wait=%b halt=%b stat=%0d cnt=%0d, required 0/0/0/1/0/0",
                     a_ph_sel, {a_phw, a_phm, a_phe, a_phf}, a_waiting, a_halted, a_clk_stat, a_inst_cnt);
        end
        checks++;
        if (b_halted !== 1'b1 || b_inst_cnt !== 32'd0 || b_ph_sel !== 4'b0) begin
            errors++;
            $display("FAIL async_reset_b: halt=%b cnt=%0d sel=%b, required 1/0/0", b_halted, b_inst_cnt, b_ph_sel);
        end
    endtask

    task automatic test_fixed_waits();
        logic [3:0] exp_sel [7]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b1000};
        logic [3:0] exp_strb [7] = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b0100, 4'b1000};
        logic       exp_wait [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        apply_reset(1'b1, 1'b1);
        for (int i = 0; i < 14; i++) begin
            tick();
            checks++;
            if (b_ph_sel !== exp_sel[i % 7] || {b_phw, b_phm, b_phe, b_phf} !== exp_strb[i % 7] ||
                b_waiting !== exp_wait[i % 7]) begin
                errors++;
                $display("FAIL fixed_waits c%0d: sel=%b strb=%b wait=%b, required %b %b %b",
                         i, b_ph_sel, {b_phw, b_phm, b_phe, b_phf}, b_waiting,
                         exp_sel[i % 7], exp_strb[i % 7], exp_wait[i % 7]);
            end
        end
        tick();
        checks++;
        if (b_inst_cnt !== 32'd2 || b_clk_stat !== 3'd1) begin
            errors++;
            $display("FAIL fixed_waits_count: cnt=%0d stat=%0d, required 2/1", b_inst_cnt, b_clk_stat);
        end
    endtask

    task automatic test_ready_stall();
        apply_reset(1'b1, 1'b0);
        tick();
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) mem_rdy = 1'b1;
            #1;
            checks++;
            if (a_ph_sel !== 4'b0001 || a_phf !== (i == 6) || a_waiting !== (i != 6) || a_phe !== 1'b0) begin
                errors++;
                $display("FAIL ready_stall c%0d: sel=%b phf=%b wait=%b phe=%b, required 0001 %b %b 0",
                         i, a_ph_sel, a_phf, a_waiting, a_phe, i == 6, i != 6);
            end
            tick();
        end
        #1;
        checks++;
        if (a_phe !== 1'b1 || a_clk_stat !== 3'd2) begin
            errors++;
            $display("FAIL ready_stall_exec: phe=%b stat=%0d, required 1/2", a_phe, a_clk_stat);
        end
    endtask

    task automatic test_single_step();
        apply_reset(1'b0, 1'b1);
        tick();
        checks++;
        if (a_halted !== 1'b1) begin
            errors++;
            $display("FAIL step_idle: halted=%b, required 1", a_halted);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        #1;
        checks++;
        if (a_phf !== 1'b1 || a_ph_sel !== 4'b0001) begin
            errors++;
            $display("FAIL step_fetch: phf=%b sel=%b, required 1/0001", a_phf, a_ph_sel);
        end
        tick();
        step = 1'b1;
        #1;
        checks++;
        if (a_phe !== 1'b1) begin
            errors++;
            $display("FAIL step_exec: phe=%b, required 1", a_phe);
        end
        tick();
        step = 1'b0;
        #1;
        checks++;
        if (a_phm !== 1'b1) begin
            errors++;
            $display("FAIL step_mem: phm=%b, required 1", a_phm);
        end
        tick();
        checks++;
        if (a_phw !== 1'b1 || a_inst_cnt !== 4'd0) begin
            errors++;
            $display("FAIL step_wb: phw=%b cnt=%0d, required 1/0", a_phw, a_inst_cnt);
        end
        tick();
        checks++;
        if (a_halted !== 1'b1 || a_inst_cnt !== 4'd1) begin
            errors++;
            $display("FAIL step_done: halted=%b cnt=%0d, required 1/1", a_halted, a_inst_cnt);
        end
        tick();
        checks++;
        if (a_halted !== 1'b1 || a_inst_cnt !== 4'd1) begin
            errors++;
            $display("FAIL step_stays: halted=%b cnt=%0d, required 1/1", a_halted, a_inst_cnt);
        end
    endtask

    task automatic test_halt_boundary();
        apply_reset(1'b1, 1'b1);
        tick();
        tick();
        tick();
        run = 1'b0;
        #1;
        checks++;
        if (a_phm !== 1'b1) begin
            errors++;
            $display("FAIL halt_mem: phm=%b, required 1", a_phm);
        end
        tick();
        checks++;
        if (a_phw !== 1'b1 || a_clk_stat !== 3'd4) begin
            errors++;
            $display("FAIL halt_wb: phw=%b stat=%0d, required 1/4", a_phw, a_clk_stat);
        end
        tick();
        checks++;
        if (a_halted !== 1'b1 || a_clk_stat !== 3'd0 || a_ph_sel !== 4'b0 || a_inst_cnt !== 4'd1) begin
            errors++;
            $display("FAIL halt_done: halted=%b stat=%0d sel=%b cnt=%0d, required 1/0/0000/1",
                     a_halted, a_clk_stat, a_ph_sel, a_inst_cnt);
        end
    endtask

    task automatic test_counter_wrap();
        logic [3:0] exp_cnt [3] = '{4'd15, 4'd0, 4'd1};
        apply_reset(1'b1, 1'b1);
        tick();
        for (int i = 0; i < 56; i++) tick();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) tick();
            checks++;
            if (a_inst_cnt !== exp_cnt[k] || a_phf !== 1'b1) begin
                errors++;
                $display("FAIL counter_wrap %0d: cnt=%0d phf=%b, required %0d/1", k, a_inst_cnt, a_phf, exp_cnt[k]);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        run     = 1'b0;
        step    = 1'b0;
        mem_rdy = 1'b1;
        test_reset();
        test_fixed_waits();
        test_ready_stall();
        test_single_step();
        test_halt_boundary();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/schedws.md
# schedws

Instruction-phase sequencer for the cpu3 datapath with run/halt/single-step control and memory wait states. It drives the four-phase fetch/exec/mem/writeback cycle. Phase levels steer the memory-address mux. One-cycle phase strobes fire register enables exactly once per phase, so slow memories can stretch fetch and memory phases without corrupting IC or load data. It replaces the fixed-rate phase scheduler between the board control logic and the CPU core.

## Interface
- `FETCH_WS`, default 0: minimum extra wait cycles in the fetch phase.
- `MEM_WS`, default 0: minimum extra wait cycles in the memory phase.
- `WS_WIDTH`, default 4: wait counter width. `FETCH_WS` and `MEM_WS` must each be < 2^`WS_WIDTH`.
- `CNT_WIDTH`, default 32: retired-instruction counter width.
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  reset, asynchronous, active-low (0 = reset).
- `run`  in  1  level; 1 = free-run, 0 = halt at the next instruction boundary.
- `step`  in  1  sampled only in HALT; 1 starts exactly one instruction.
- `mem_rdy`  in  1  memory ready; completes the fetch and memory phases.
- `ph_sel`  out  4  one-hot current phase {W,M,E,F}, held for the whole phase; 0 in HALT.
- `phf`, `phe`, `phm`, `phw`  out  1 each  one-cycle completion strobes for fetch, exec, mem and writeback.
- `waiting`  out  1  in F or M and not completing this cycle.
- `halted`  out  1  state is HALT.
- `inst_cnt`  out  `CNT_WIDTH`  retired instructions.
- `clk_stat`  out  3  0 = HALT, 1 = F, 2 = E, 3 = M, 4 = W.

## Operation
- States: HALT, F, E, M, W.
- On `reset`=0, all of the following take effect asynchronously and immediately:
  - state becomes HALT;
  - wait counter is 0;
  - `inst_cnt`=0;
  - `ph_sel`=0, all strobes 0, `waiting`=0, `clk_stat`=0, `halted`=1.
- HALT exits:
  - `run`=1 → F;
  - else `step`=1 → F;
  - else stay in HALT.
- On entering F, the wait counter loads `FETCH_WS`. On entering M, it loads `MEM_WS`.
- In F or M, each cycle with counter ≠ 0 decrements the counter. `mem_rdy` is ignored while the counter is ≠ 0.
- F completes in the first cycle with counter = 0 and `mem_rdy`=1. In that cycle `phf`=1 and the next state is E. M behaves the same way with `phm`, and its next state is W.
- E is always one cycle: `phe`=1, next state M.
- W is always one cycle: `phw`=1 and `inst_cnt` increments, wrapping modulo 2^`CNT_WIDTH`. Next state is F if `run`=1, else HALT.
- Mid-instruction changes of `run` have no effect until the W cycle; the instruction always completes.
- A single step always returns to HALT after one instruction when `run`=0. `step` held high re-triggers one instruction per HALT visit.
- `step` outside HALT is ignored. `run`=1 with `step`=1 in HALT is equivalent to `run` alone.
- Strobes are Mealy outputs, decoded combinationally from state, counter and `mem_rdy` (`phf` = F & cnt==0 & `mem_rdy`). `ph_sel`, `halted` and `clk_stat` decode from state only.

## Timing
- Latency from HALT: `run` sampled 1 at edge N gives state F in cycle N+1.
- Zero-wait free run (`FETCH_WS`=`MEM_WS`=0, `mem_rdy`=1):
  - 4 cycles per instruction;
  - strobes `phf`, `phe`, `phm`, `phw` in consecutive cycles;
  - `ph_sel` equals the strobe pattern.
- F duration in cycles = max(`FETCH_WS`+1, index of the first cycle with `mem_rdy`=1 and counter 0). M duration follows the same rule with `MEM_WS`.
- Minimum instruction length is 4 + `FETCH_WS` + `MEM_WS` cycles.
- Back-to-back instructions have no HALT gap while `run`=1.
- `waiting` = (F|M) & ~strobe.

## Test plan
- Reset and free run, zero waits:
  - stimulus: assert `reset`=0 mid-phase, then release with `run`=1;
  - response: outputs go to reset values immediately; HALT for exactly 1 cycle; then strobes F,E,M,W repeat every 4 cycles; `inst_cnt`=3 after 12 cycles in F..W.
- Fixed waits:
  - stimulus: `FETCH_WS`=2, `MEM_WS`=1, `mem_rdy`=1;
  - response: F lasts 3 cycles with `waiting`=1 for the first 2; M lasts 2 cycles; 7-cycle period; one strobe per phase.
- Ready stall:
  - stimulus: waits 0; `mem_rdy`=0 for 5 cycles in F, then 1;
  - response: `phf` only in cycle 6 of F; `ph_sel`=0001 throughout F; `phe` in the next cycle.
- Single step:
  - stimulus: `run`=0, 1-cycle `step` pulse in HALT;
  - response: exactly one F,E,M,W sequence; HALT again; `inst_cnt` +1; a `step` pulse during E has no effect.
- Halt boundary:
  - stimulus: drop `run` during M;
  - response: W completes with `phw`; next state HALT; `halted`=1, `clk_stat`=0.
- Counter wrap:
  - stimulus: `CNT_WIDTH`=4, run 17 instructions;
  - response: `inst_cnt` reads 15, then 0, then 1.
